// File: rtl/ula_if.sv
// Operand/result/status bundle between the REDUX-V datapath and its ALU.
// The datapath side drives operands and opcode; the ALU drives result and flags.
interface ula_if #(
   parameter int BITS   = 8,
   parameter int ULA_OP = 4
);
   logic [BITS-1:0]   a_in;
   logic [BITS-1:0]   b_in;
   logic [ULA_OP-1:0] ula_op_in;
   logic              flags_en_in;
   logic [BITS-1:0]   result_out;
   logic              zero_out;
   logic              neg_out;
   logic              carry_out;
   logic              ovf_out;

   modport master (
      output a_in, b_in, ula_op_in, flags_en_in,
      input  result_out, zero_out, neg_out, carry_out, ovf_out
   );

   modport slave (
      input  a_in, b_in, ula_op_in, flags_en_in,
      output result_out, zero_out, neg_out, carry_out, ovf_out
   );
endinterface

// File: rtl/ula.sv
// REDUX-V arithmetic/logic unit: combinational result plus a registered
// zero/negative/carry/overflow flag set consumed by the branch logic.
module ula #(
   parameter int ULA_OP = 4,
   parameter int BITS   = 8
) (
   input logic clk_in,
   input logic rst_in,
   ula_if.slave bus
);

   localparam int SH_W = $clog2(BITS);

   typedef enum logic [ULA_OP-1:0] {
      OP_NOT   = 'd0,
      OP_AND   = 'd1,
      OP_OR    = 'd2,
      OP_XOR   = 'd3,
      OP_ADD   = 'd4,
      OP_SUB   = 'd5,
      OP_SLL   = 'd6,
      OP_SRL   = 'd7,
      OP_PASSB = 'd8,
      OP_PASSA = 'd9
   } ula_op_t;

   logic [BITS-1:0] a;
   logic [BITS-1:0] b;
   logic [SH_W-1:0] sh;
   logic [BITS:0]   sum;
   logic [BITS:0]   diff;
   logic [BITS:0]   sll_ext;
   logic [BITS:0]   srl_ext;

   logic [BITS-1:0] res;
   logic            carry_nxt;
   logic            ovf_nxt;

   logic zero_q;
   logic neg_q;
   logic carry_q;
   logic ovf_q;

   assign a  = bus.a_in;
   assign b  = bus.b_in;
   // Shift amount is masked to log2(BITS) bits, so it can never reach BITS.
   assign sh = b[SH_W-1:0];

   // The extra bit of each widened operation is exactly the carry/borrow or
   // the last bit shifted out; a zero shift leaves that extra bit at 0.
   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} - {1'b0, b};
   assign sll_ext = {1'b0, a} << sh;
   assign srl_ext = {a, 1'b0} >> sh;

   always_comb begin
      res       = '0;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      case (bus.ula_op_in)
         OP_NOT:   res = ~b;
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_XOR:   res = a ^ b;
         OP_ADD: begin
            res       = sum[BITS-1:0];
            carry_nxt = sum[BITS];
            ovf_nxt   = (a[BITS-1] == b[BITS-1]) && (sum[BITS-1] != a[BITS-1]);
         end
         OP_SUB: begin
            res       = diff[BITS-1:0];
            carry_nxt = diff[BITS];
            ovf_nxt   = (a[BITS-1] != b[BITS-1]) && (diff[BITS-1] != a[BITS-1]);
         end
         OP_SLL: begin
            res       = sll_ext[BITS-1:0];
            carry_nxt = sll_ext[BITS];
         end
         OP_SRL: begin
            res       = srl_ext[BITS:1];
            carry_nxt = srl_ext[0];
         end
         OP_PASSB: res = b;
         OP_PASSA: res = a;
         default: begin
            res       = '0;
            carry_nxt = 1'b0;
         end
      endcase
   end

   assign bus.result_out = res;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.flags_en_in) begin
         zero_q  <= (res == '0);
         neg_q   <= res[BITS-1];
         carry_q <= carry_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   assign bus.zero_out  = zero_q;
   assign bus.neg_out   = neg_q;
   assign bus.carry_out = carry_q;
   assign bus.ovf_out   = ovf_q;

endmodule

// File: tb/tb_ula.sv
// Directed self-checking bench for ula: combinational opcodes, flag capture,
// flag hold and asynchronous reset behaviour.
module tb_ula;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ula_if #(.BITS(8), .ULA_OP(4)) bus ();

   ula #(.ULA_OP(4), .BITS(8)) u_dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive an operation, then land 1 time unit after the next rising edge.
   task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic en);
      bus.ula_op_in   = op;
      bus.a_in        = a;
      bus.b_in        = b;
      bus.flags_en_in = en;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [3:0] fl;
      #1;
      fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
      n_checks++;
      if (fl !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected %b", fl, 4'b0000);
      end
      n_checks++;
      if (bus.result_out !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_result: got %h expected %h", bus.result_out, 8'hFF);
      end
      step(4'd4, 8'hFF, 8'h01, 1'b1);
      fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
      n_checks++;
      if (fl !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_held_flags: got %b expected %b", fl, 4'b0000);
      end
      rst = 1'b0;
   endtask

   task automatic test_not;
      int bad;
      bad = 0;
      bus.ula_op_in = 4'd0;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            bus.a_in = a[7:0];
            bus.b_in = b[7:0];
            #1;
            n_checks++;
            if (bus.result_out !== ~b[7:0]) begin
               n_fail++;
               if (bad < 8)
                  $display("FAIL not a=%h b=%h: got %h expected %h", a[7:0], b[7:0],
                           bus.result_out, ~b[7:0]);
               bad++;
            end
         end
      end
   endtask

   task automatic test_logic;
      logic [3:0] ops [6]  = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd8, 4'd15};
      logic [7:0] exps [6] = '{8'h30, 8'hFC, 8'hCC, 8'hF0, 8'h3C, 8'h00};
      bus.a_in = 8'hF0;
      bus.b_in = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         bus.ula_op_in = ops[i];
         #1;
         n_checks++;
         if (bus.result_out !== exps[i]) begin
            n_fail++;
            $display("FAIL logic op=%0d: got %h expected %h", ops[i], bus.result_out, exps[i]);
         end
      end
   endtask

   // Each row: op, a, b, expected result, expected {zero,neg,carry,ovf}.
   task automatic test_arith_shift;
      logic [3:0] ops [10] = '{4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd6, 4'd6, 4'd7, 4'd10};
      logic [7:0] as  [10] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
      logic [7:0] bs  [10] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h01, 8'h01, 8'h00, 8'h09, 8'h09, 8'hFF};
      logic [7:0] rs  [10] = '{8'h00, 8'h80, 8'hFE, 8'h7F, 8'h02, 8'h40, 8'h81, 8'h02, 8'h40, 8'h00};
      logic [3:0] fs  [10] = '{4'b1010, 4'b0101, 4'b0110, 4'b0001, 4'b0010,
                              4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b1000};
      logic [3:0] fl;
      for (int i = 0; i < 10; i++) begin
         bus.ula_op_in = ops[i];
         bus.a_in      = as[i];
         bus.b_in      = bs[i];
         #1;
         n_checks++;
         if (bus.result_out !== rs[i]) begin
            n_fail++;
            $display("FAIL arith_result row=%0d: got %h expected %h", i, bus.result_out, rs[i]);
         end
         step(ops[i], as[i], bs[i], 1'b1);
         fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
         n_checks++;
         if (fl !== fs[i]) begin
            n_fail++;
            $display("FAIL arith_flags row=%0d: got %b expected %b", i, fl, fs[i]);
         end
      end
   endtask

   task automatic test_flag_hold;
      logic [3:0] fl;
      step(4'd4, 8'hFF, 8'h01, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(4'd9, 8'h55, 8'h00, 1'b0);
         fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
         n_checks++;
         if (fl !== 4'b1010) begin
            n_fail++;
            $display("FAIL hold edge=%0d: got %b expected %b", i, fl, 4'b1010);
         end
      end
      n_checks++;
      if (bus.result_out !== 8'h55) begin
         n_fail++;
         $display("FAIL hold_result: got %h expected %h", bus.result_out, 8'h55);
      end
   endtask

   task automatic test_async_reset;
      logic [3:0] fl;
      step(4'd4, 8'h7F, 8'h01, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
      n_checks++;
      if (fl !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset_flags: got %b expected %b", fl, 4'b0000);
      end
      bus.ula_op_in = 4'd9;
      bus.a_in      = 8'h3C;
      #1;
      n_checks++;
      if (bus.result_out !== 8'h3C) begin
         n_fail++;
         $display("FAIL async_reset_result: got %h expected %h", bus.result_out, 8'h3C);
      end
      rst = 1'b0;
      step(4'd5, 8'h05, 8'h07, 1'b1);
      fl = {bus.zero_out, bus.neg_out, bus.carry_out, bus.ovf_out};
      n_checks++;
      if (fl !== 4'b0110) begin
         n_fail++;
         $display("FAIL post_reset_capture: got %b expected %b", fl, 4'b0110);
      end
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.a_in        = 8'h00;
      bus.b_in        = 8'h00;
      bus.ula_op_in   = 4'd0;
      bus.flags_en_in = 1'b0;
      test_reset();
      test_not();
      test_logic();
      test_arith_shift();
      test_flag_hold();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
